// File: rtl/sram_1rw1r_sync.sv
// sram_1rw1r_sync: synchronous SRAM with one read/write port (port 0, lane-masked
// writes) and one read-only port (port 1). Reads complete READ_LATENCY edges after
// the request. After reset an optional clear sequence zeroes the array one word per
// cycle while busy is high.
//
// Ports:
//   clk          single clock, all inputs sampled on its rising edge
//   rst          synchronous active-high reset
//   csb0, web0   port-0 chip select / write enable, both active low
//   wmask0       port-0 per-lane write enable, active high
//   addr0, din0  port-0 address / write data
//   dout0        port-0 read data, holds its last value between reads
//   dout0_valid  one-cycle strobe when dout0 carries new read data
//   csb1, addr1  port-1 chip select (active low) / address
//   dout1        port-1 read data
//   dout1_valid  one-cycle strobe for dout1
//   busy         high while the clear sequence runs; requests are dropped meanwhile
module sram_1rw1r_sync #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned NUM_WMASKS     = 4,
    parameter int unsigned READ_LATENCY   = 1,
    parameter bit          WRITE_FIRST    = 1'b1,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_valid,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic                  busy
);

    localparam int unsigned RAM_DEPTH  = 2 ** ADDR_WIDTH;
    localparam int unsigned LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StReady = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  clearing;

    logic                  rd0_req, rd1_req, wr0_req;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd1_word;

    logic                  rd0_vld_q, rd1_vld_q;
    logic [DATA_WIDTH-1:0] rd0_data_q, rd1_data_q;

    assign clearing = (state_q == StClear);
    assign busy     = clearing;

    assign rd0_req = !clearing && !csb0 && web0;
    assign rd1_req = !clearing && !csb1;
    assign wr0_req = !clearing && !csb0 && !web0;

    // Word as it will look after this edge's port-0 write (old lanes where mask is 0).
    always_comb begin
        wr_merged = mem[addr0];
        for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
                wr_merged[i*LANE_WIDTH +: LANE_WIDTH] = din0[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // Same-address collision on port 1: forward the merged word when write-first.
    always_comb begin
        rd1_word = mem[addr1];
        if (WRITE_FIRST && wr0_req && (addr1 == addr0)) begin
            rd1_word = wr_merged;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (clearing) begin
            clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
            if (clr_cnt_q == LastAddr) begin
                state_d = StReady;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? StClear : StReady;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Array has no reset of its own; only the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clearing) begin
                mem[clr_cnt_q] <= '0;
            end else if (wr0_req && (|wmask0)) begin
                mem[addr0] <= wr_merged;
            end
        end
    end

    // First read stage; data registers only load on a read so outputs hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd0_vld_q  <= 1'b0;
            rd1_vld_q  <= 1'b0;
            rd0_data_q <= '0;
            rd1_data_q <= '0;
        end else begin
            rd0_vld_q <= rd0_req;
            rd1_vld_q <= rd1_req;
            if (rd0_req) begin
                rd0_data_q <= mem[addr0];
            end
            if (rd1_req) begin
                rd1_data_q <= rd1_word;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  out0_vld_q, out1_vld_q;
        logic [DATA_WIDTH-1:0] out0_data_q, out1_data_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                out0_vld_q  <= 1'b0;
                out1_vld_q  <= 1'b0;
                out0_data_q <= '0;
                out1_data_q <= '0;
            end else begin
                out0_vld_q <= rd0_vld_q;
                out1_vld_q <= rd1_vld_q;
                if (rd0_vld_q) begin
                    out0_data_q <= rd0_data_q;
                end
                if (rd1_vld_q) begin
                    out1_data_q <= rd1_data_q;
                end
            end
        end

        assign dout0       = out0_data_q;
        assign dout0_valid = out0_vld_q;
        assign dout1       = out1_data_q;
        assign dout1_valid = out1_vld_q;
    end else begin : g_lat1
        assign dout0       = rd0_data_q;
        assign dout0_valid = rd0_vld_q;
        assign dout1       = rd1_data_q;
        assign dout1_valid = rd1_vld_q;
    end

endmodule
